// File: rtl/dff_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dff_pipe
// Purpose  : WIDTH-bit, DEPTH-stage register pipeline with valid/ready flow
//            control, per-stage bubble collapsing and a registered occupancy
//            count. With DEPTH=1 and out_ready tied high it behaves as a
//            registered D flip-flop that also carries a valid flag.
// Ports    : clk        - rising-edge clock
//            rst        - synchronous active-high reset
//            inp        - producer data           in_valid  - producer valid
//            in_ready   - pipeline accepts inp this cycle
//            outp       - data at the last stage  out_valid - outp is valid
//            out_ready  - consumer accepts outp this cycle
//            count      - number of occupied stages (0..DEPTH)
//            parity_err - parity mismatch on outp (parity build only, else 0)
// Config   : `define DFF_PIPE_PARITY_EN to store an even-parity bit per stage
//            and flag a mismatch on the output stage.
// Revision : 1.0 - initial release
// ============================================================================
module dff_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inp,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] outp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             parity_err
);

    // Stage storage
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_v;
    logic [CW-1:0]    r_count;

    // Advance enables: w_rdy[i] high means stage i loads from upstream this
    // edge. An empty stage always loads, which is what collapses bubbles.
    logic [DEPTH:0]   w_rdy;
    logic [DEPTH-1:0] w_up_v;
    logic [WIDTH-1:0] w_up_data [DEPTH];
    logic [DEPTH-1:0] w_v_next;
    logic [CW-1:0]    w_count_next;

    assign w_rdy[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign w_up_v[i]    = in_valid;
            assign w_up_data[i] = inp;
        end else begin : g_body
            assign w_up_v[i]    = r_v[i-1];
            assign w_up_data[i] = r_data[i-1];
        end
        assign w_rdy[i]    = !r_v[i] || w_rdy[i+1];
        assign w_v_next[i] = w_rdy[i] ? w_up_v[i] : r_v[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_v[i]    <= 1'b0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i]) begin
                    r_v[i]    <= w_up_v[i];
                    r_data[i] <= w_up_data[i];
                end
            end
        end
    end

    // Occupancy is the popcount of the next valid vector, so count moves on
    // the same edge as the valid flags themselves.
    always_comb begin
        w_count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count_next = w_count_next + CW'(w_v_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

`ifdef DFF_PIPE_PARITY_EN
    // One parity bit travels alongside each data word.
    logic [DEPTH-1:0] r_p;
    logic [DEPTH-1:0] w_up_p;

    for (genvar i = 0; i < DEPTH; i++) begin : g_par
        if (i == 0) begin : g_head
            assign w_up_p[i] = ^inp;
        end else begin : g_body
            assign w_up_p[i] = r_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i]) begin
                    r_p[i] <= w_up_p[i];
                end
            end
        end
    end

    assign parity_err = r_v[DEPTH-1] && ((^r_data[DEPTH-1]) != r_p[DEPTH-1]);
`else
    assign parity_err = 1'b0;
`endif

    assign in_ready  = w_rdy[0];
    assign outp      = r_data[DEPTH-1];
    assign out_valid = r_v[DEPTH-1];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_pipe
// Purpose  : Scoreboard bench for dff_pipe (WIDTH=8, DEPTH=4). The driver
//            pushes expected words when the pipeline accepts them; a monitor
//            pops and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] inp = 8'hA5;
    logic             in_valid = 1'b1;
    logic             in_ready;
    logic [WIDTH-1:0] outp;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CW-1:0]    count;
    logic             parity_err;

    dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .inp        (inp),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .outp       (outp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               acc;
    } ent_t;

    ent_t sb[$];
    ent_t mon_e;
    int   cyc          = 0;
    int   n_checks     = 0;
    int   n_errors     = 0;
    int   n_acc        = 0;
    bit   lat_check    = 0;
    bit   stream_check = 0;
    bit   full_check   = 0;
    logic expect_perr  = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes on the next posedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_out: got %0h expected nothing", outp);
            end else begin
                mon_e = sb.pop_front();
                chk("outp", 32'(outp), 32'(mon_e.d));
                if (lat_check) chk("latency", 32'(cyc - mon_e.acc), 32'(DEPTH - 1));
                chk("parity_err", 32'(parity_err), 32'(expect_perr));
                expect_perr = 1'b0;
            end
        end
    end

    // Driver: accept happens on the posedge following a negedge with in_ready.
    task automatic push(input logic [WIDTH-1:0] d);
        bit done = 0;
        in_valid = 1'b1;
        inp      = d;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                if (full_check)   chk("count_full", 32'(count), 32'(DEPTH));
                if (stream_check) chk("count_stream", 32'(count),
                                      32'((n_acc < DEPTH) ? n_acc : DEPTH));
                sb.push_back('{d, cyc + 1});
                n_acc++;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("push_timeout", 32'(d), 32'hFFFF_FFFF);
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && count == 0 && !out_valid) done = 1;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two edges with a valid word presented.
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_outp",      32'(outp),      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Streaming 0x01..0x10, consumer always ready.
        out_ready    = 1'b1;
        n_acc        = 0;
        lat_check    = 1;
        stream_check = 1;
        for (int i = 1; i <= 16; i++) push(WIDTH'(i));
        stream_check = 0;
        wait_empty();
        lat_check = 0;

        // Back-pressure: 6 words into a stalled 4-deep pipe.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) push(WIDTH'(i));
            end
            begin
                repeat (6) @(negedge clk);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_count",    32'(count),    32'd4);
                chk("bp_outp",     32'(outp),     32'h01);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_empty();

        // Bubble collapse with consumer stalled.
        out_ready = 1'b0;
        push(8'h11);
        repeat (2) @(posedge clk);
        #1;
        push(8'h22);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bub_count",    32'(count),          32'd2);
        chk("bub_in_ready", 32'(in_ready),       32'd1);
        chk("bub_v",        32'(dut.r_v),        32'b1100);
        chk("bub_stage3",   32'(dut.r_data[3]),  32'h11);
        chk("bub_stage2",   32'(dut.r_data[2]),  32'h22);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_empty();

        // Fill, then accept and pop simultaneously while full.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(WIDTH'(8'hA0 + i));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        out_ready  = 1'b1;
        full_check = 1;
        for (int i = 4; i < 8; i++) push(WIDTH'(8'hA0 + i));
        full_check = 0;
        wait_empty();

        // Reset mid-stream with three words held.
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) push(WIDTH'(8'hB0 + i));
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_count",    32'(count),     32'd0);
        chk("mid_rst_valid",    32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_rst_stay_empty", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

`ifdef DFF_PIPE_PARITY_EN
        // Corrupt the word sitting in the output stage.
        out_ready = 1'b0;
        push(8'h07);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        @(negedge clk);
        chk("par_clean", 32'(parity_err), 32'd0);
        dut.r_data[DEPTH-1][0] = ~dut.r_data[DEPTH-1][0];
        #1;
        chk("par_flip", 32'(parity_err), 32'd1);
        sb[0].d     = 8'h06;
        expect_perr = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push(8'h0F);
        wait_empty();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
